// File: rtl/piso_ser.sv
// Parallel-in serial-out converter: accepts words over valid/ready, shifts one bit per
// enabled clock, and counts fully shifted words.
module piso_ser #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int unsigned   IW      = $clog2(WIDTH);
    localparam logic [IW-1:0] LastIdx = IW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             sout_q, sout_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IW-1:0]    idx_nxt;
    logic [IW-1:0]    bit_pos;
    logic             word_done;
    logic             load;

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        idx_d     = idx_q;
        sout_d    = sout_q;
        valid_d   = valid_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        din_ready = 1'b0;

        idx_nxt = idx_q + IW'(1);
        bit_pos = MSB_FIRST ? (LastIdx - idx_nxt) : idx_nxt;

        unique case (state_q)
            StIdle:  din_ready = 1'b1;
            StShift: din_ready = last_q && shift_en;
            default: din_ready = 1'b0;
        endcase

        word_done = (state_q == StShift) && last_q && shift_en;
        load      = din_valid && din_ready;

        if (word_done) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // A load on the completing edge takes priority so back-to-back words have no bubble.
        if (load) begin
            state_d = StShift;
            sreg_d  = din;
            idx_d   = '0;
            sout_d  = MSB_FIRST ? din[WIDTH-1] : din[0];
            valid_d = 1'b1;
            last_d  = 1'b0;
        end else if (word_done) begin
            state_d = StIdle;
            idx_d   = '0;
            sout_d  = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else if ((state_q == StShift) && shift_en) begin
            idx_d  = idx_nxt;
            sout_d = sreg_q[bit_pos];
            last_d = (idx_nxt == LastIdx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            idx_q   <= '0;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            idx_q   <= idx_d;
            sout_q  <= sout_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sout       = sout_q;
    assign sout_valid = valid_q;
    assign sout_last  = last_q;
    assign busy       = valid_q;
    assign word_cnt   = cnt_q;

endmodule

// File: tb/tb_piso_ser.sv
// Bench for piso_ser: three instances (default, LSB-first, 4-bit counter) share stimulus
// and are compared each cycle with a word-level reference model.
module tb_piso_ser;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       shift_en;

    logic        din_ready, sout, sout_valid, sout_last, busy;
    logic [15:0] word_cnt;
    logic        din_ready_l, sout_l, sv_l, sl_l, bz_l;
    logic [15:0] wc_l;
    logic        din_ready_c, sout_c, sv_c, sl_c, bz_c;
    logic [3:0]  wc_c;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    piso_ser #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .shift_en(shift_en), .sout(sout), .sout_valid(sout_valid), .sout_last(sout_last),
        .busy(busy), .word_cnt(word_cnt)
    );

    piso_ser #(.WIDTH(8), .MSB_FIRST(1'b0), .CNT_W(16)) dut_l (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready_l),
        .shift_en(shift_en), .sout(sout_l), .sout_valid(sv_l), .sout_last(sl_l),
        .busy(bz_l), .word_cnt(wc_l)
    );

    piso_ser #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready_c),
        .shift_en(shift_en), .sout(sout_c), .sout_valid(sv_c), .sout_last(sl_c),
        .busy(bz_c), .word_cnt(wc_c)
    );

    logic [47:0] obs;
    assign obs = {sout_valid, busy, sout_last, sout, sv_l, bz_l, sl_l, sout_l,
                  sv_c, bz_c, sl_c, sout_c, word_cnt, wc_l, wc_c};

    // Reference model: word in flight, number of bits already presented, words completed.
    bit          m_active;
    logic [7:0]  m_word;
    int          m_k;
    int unsigned m_cnt;
    bit          rdy_exp;
    logic [2:0]  rdy_got;

    function automatic logic [47:0] exp_vec();
        logic v, l, sm, sl;
        v  = m_active;
        l  = m_active && (m_k == 7);
        sm = m_active ? m_word[7 - m_k] : 1'b0;
        sl = m_active ? m_word[m_k] : 1'b0;
        return {v, v, l, sm, v, v, l, sl, v, v, l, sm, 16'(m_cnt), 16'(m_cnt), 4'(m_cnt)};
    endfunction

    task automatic model_clear();
        m_active = 1'b0;
        m_word   = '0;
        m_k      = 0;
        m_cnt    = 0;
    endtask

    // One clock: sample ready before the edge, advance the model on the edge, return at +1.
    task automatic step(output bit acc);
        bit         done;
        logic [7:0] din_s;
        #1;
        rdy_exp = !m_active || (m_k == 7 && shift_en);
        rdy_got = {din_ready, din_ready_l, din_ready_c};
        done    = m_active && (m_k == 7) && shift_en;
        acc     = din_valid && rdy_exp;
        din_s   = din;
        @(posedge clk);
        if (done) m_cnt++;
        if (acc) begin
            m_word = din_s; m_k = 0; m_active = 1'b1;
        end else if (done) begin
            m_active = 1'b0; m_k = 0;
        end else if (m_active && shift_en) begin
            m_k++;
        end
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        model_clear();
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; din = 8'h00; din_valid = 1'b0; shift_en = 1'b0;
        model_clear();
        #2;
        tests++;
        if ({din_ready, din_ready_l, din_ready_c, obs} !== {3'b111, 48'b0}) begin
            fails++;
            $display("FAIL reset_async: got rdy=%b out=%h exp rdy=111 out=0",
                     {din_ready, din_ready_l, din_ready_c}, obs);
        end
        @(posedge clk); @(posedge clk); #3;
        tests++;
        if (obs !== 48'b0) begin
            fails++;
            $display("FAIL reset_hold: got %h exp 0", obs);
        end
        rst = 1'b0;
    endtask

    // Single word with full shift_en; checks bit stream and last-flag placement.
    task automatic test_single(input string name, input logic [7:0] w,
                               input logic [7:0] exp_m, input logic [7:0] exp_l);
        bit acc;
        logic [7:0] col_m, col_l, col_last;
        int unsigned c0;
        c0 = m_cnt;
        din = w; din_valid = 1'b1; shift_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step(acc);
            if (i == 0) din_valid = 1'b0;
            tests++;
            if ({rdy_got, obs} !== {{3{rdy_exp}}, exp_vec()}) begin
                fails++;
                $display("FAIL %s cyc %0d: got rdy=%b out=%h exp rdy=%b out=%h",
                         name, i, rdy_got, obs, rdy_exp, exp_vec());
            end
            if (i < 8) begin
                col_m = {col_m[6:0], sout};
                col_l = {col_l[6:0], sout_l};
                col_last = {col_last[6:0], sout_last};
            end
        end
        tests++;
        if ({col_m, col_l, col_last, sout_valid, word_cnt} !==
            {exp_m, exp_l, 8'h01, 1'b0, 16'(c0 + 1)}) begin
            fails++;
            $display("FAIL %s stream: got m=%h l=%h last=%h v=%b cnt=%0d exp m=%h l=%h last=01 v=0 cnt=%0d",
                     name, col_m, col_l, col_last, sout_valid, word_cnt, exp_m, exp_l, c0 + 1);
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        logic [15:0] col;
        logic [16:0] rdyv;
        logic [15:0] vcol;
        int unsigned c0;
        c0 = m_cnt;
        din = 8'hA5; din_valid = 1'b1; shift_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step(acc);
            rdyv[i] = rdy_got[2];
            if (acc && i == 0) din = 8'h3C;
            if (acc && i == 8) din_valid = 1'b0;
            tests++;
            if ({rdy_got, obs} !== {{3{rdy_exp}}, exp_vec()}) begin
                fails++;
                $display("FAIL b2b cyc %0d: got rdy=%b out=%h exp rdy=%b out=%h",
                         i, rdy_got, obs, rdy_exp, exp_vec());
            end
            if (i < 16) begin
                col = {col[14:0], sout};
                vcol = {vcol[14:0], sout_valid};
            end
        end
        tests++;
        if ({col, vcol, rdyv, word_cnt} !== {16'hA53C, 16'hFFFF, 17'h10101, 16'(c0 + 2)}) begin
            fails++;
            $display("FAIL b2b stream: got bits=%h valid=%h rdy=%h cnt=%0d exp bits=a53c valid=ffff rdy=10101 cnt=%0d",
                     col, vcol, rdyv, word_cnt, c0 + 2);
        end
    endtask

    task automatic test_stall();
        bit acc;
        logic [10:0] col, col_last;
        din = 8'hF0; din_valid = 1'b1; shift_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(acc);
            if (i == 0) din_valid = 1'b0;
            if (i == 1) shift_en = 1'b0;
            if (i == 4) shift_en = 1'b1;
            tests++;
            if ({rdy_got, obs} !== {{3{rdy_exp}}, exp_vec()}) begin
                fails++;
                $display("FAIL stall cyc %0d: got rdy=%b out=%h exp rdy=%b out=%h",
                         i, rdy_got, obs, rdy_exp, exp_vec());
            end
            if (i < 11) begin
                col = {col[9:0], sout};
                col_last = {col_last[9:0], sout_last};
            end
        end
        tests++;
        if ({col, col_last} !== {11'h7F0, 11'h001}) begin
            fails++;
            $display("FAIL stall stream: got bits=%h last=%h exp bits=7f0 last=001", col, col_last);
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        logic [7:0] col;
        din = 8'hFF; din_valid = 1'b1; shift_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(acc);
            if (i == 0) din_valid = 1'b0;
        end
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        tests++;
        if ({din_ready, din_ready_l, din_ready_c, obs} !== {3'b111, 48'b0}) begin
            fails++;
            $display("FAIL reset_mid: got rdy=%b out=%h exp rdy=111 out=0",
                     {din_ready, din_ready_l, din_ready_c}, obs);
        end
        #2;
        rst = 1'b0;
        din = 8'h80; din_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(acc);
            if (i == 0) begin
                din_valid = 1'b0;
                tests++;
                if (acc !== 1'b1) begin
                    fails++;
                    $display("FAIL reset_mid_load: got accepted=%b exp 1", acc);
                end
            end
            tests++;
            if ({rdy_got, obs} !== {{3{rdy_exp}}, exp_vec()}) begin
                fails++;
                $display("FAIL reset_mid cyc %0d: got rdy=%b out=%h exp rdy=%b out=%h",
                         i, rdy_got, obs, rdy_exp, exp_vec());
            end
            col = {col[6:0], sout};
        end
        tests++;
        if (col !== 8'h80) begin
            fails++;
            $display("FAIL reset_mid stream: got %h exp 80", col);
        end
    endtask

    task automatic test_wrap();
        bit acc;
        int n_acc;
        pulse_reset();
        n_acc = 0;
        din = 8'($urandom); din_valid = 1'b1; shift_en = 1'b1;
        for (int i = 0; i < 200 && m_cnt < 16; i++) begin
            step(acc);
            if (acc) begin
                n_acc++;
                if (n_acc == 16) din_valid = 1'b0;
                else din = 8'($urandom);
            end
            tests++;
            if ({rdy_got, obs} !== {{3{rdy_exp}}, exp_vec()}) begin
                fails++;
                $display("FAIL wrap cyc %0d: got rdy=%b out=%h exp rdy=%b out=%h",
                         i, rdy_got, obs, rdy_exp, exp_vec());
            end
        end
        tests++;
        if ({word_cnt, wc_c, sout_valid} !== {16'd16, 4'd0, 1'b0}) begin
            fails++;
            $display("FAIL wrap end: got cnt=%0d cnt4=%0d v=%b exp cnt=16 cnt4=0 v=0",
                     word_cnt, wc_c, sout_valid);
        end
    endtask

    task automatic test_random();
        bit acc;
        din_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!din_valid) begin
                din = 8'($urandom);
                din_valid = ($urandom % 2) == 1;
            end
            shift_en = ($urandom % 4) != 0;
            step(acc);
            if (acc) din_valid = 1'b0;
            tests++;
            if ({rdy_got, obs} !== {{3{rdy_exp}}, exp_vec()}) begin
                fails++;
                $display("FAIL random cyc %0d: got rdy=%b out=%h exp rdy=%b out=%h",
                         i, rdy_got, obs, rdy_exp, exp_vec());
            end
        end
        din_valid = 1'b0; shift_en = 1'b1;
        for (int i = 0; i < 20 && m_active; i++) begin
            step(acc);
            tests++;
            if ({rdy_got, obs} !== {{3{rdy_exp}}, exp_vec()}) begin
                fails++;
                $display("FAIL drain cyc %0d: got rdy=%b out=%h exp rdy=%b out=%h",
                         i, rdy_got, obs, rdy_exp, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single("basic", 8'hA5, 8'hA5, 8'hA5);
        test_single("lsb", 8'h01, 8'h01, 8'h80);
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
